// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI frame-buffer read scheduler.
package hdmi_pkg;

  localparam int WORD_BYTES = 32;
  localparam int FW_W       = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    RUN   = 2'd2,
    WAIT  = 2'd3
  } state_e;

endpackage

// File: rtl/hdmi_rd_credit.sv
// Outstanding-word tracker for the pixel FIFO. It also decides whether the
// FIFO has room for a candidate burst and flags data returned unexpectedly.
module hdmi_rd_credit #(
  parameter int LVL_W      = 10,
  parameter int FIFO_DEPTH = 512
) (
  input  logic             clk,
  input  logic             sync_rst,
  input  logic             ack_fire,
  input  logic [7:0]       ack_len,
  input  logic             data_vld,
  input  logic [LVL_W-1:0] fifo_wr_cnt,
  input  logic [7:0]       req_len,
  output logic [LVL_W:0]   outst,
  output logic             credit_ok,
  output logic             rsp_err
);

  localparam int OW    = LVL_W + 1;
  localparam int SUM_W = LVL_W + 2;

  logic [SUM_W-1:0] need;
  logic [OW-1:0]    add;
  logic [OW-1:0]    sub;
  logic             dec;

  // Two extra bits cover the level, the in-flight words and the burst at once.
  assign need      = SUM_W'(fifo_wr_cnt) + SUM_W'(outst) + SUM_W'(req_len);
  assign credit_ok = (need <= SUM_W'(FIFO_DEPTH));

  // A word arriving with nothing in flight is an error; the count must not wrap.
  assign dec = data_vld && (outst != '0);
  assign add = ack_fire ? OW'(ack_len) : '0;
  assign sub = OW'(dec);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of the order of the statements.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      outst   <= '0;
      rsp_err <= 1'b0;
    end else begin
      outst <= outst + add - sub;
      if (data_vld && (outst == '0)) rsp_err <= 1'b1;
    end
  end

endmodule

// File: rtl/hdmi_rd_sched.sv
// Per-frame burst read scheduler: it restarts on vsync, drains the reads still
// in flight, flushes the pixel FIFO, then issues bursts when the FIFO has room.
module hdmi_rd_sched
  import hdmi_pkg::*;
#(
  parameter int FRAME_WORDS = 259200,
  parameter int BURST_LEN   = 64,
  parameter int FIFO_DEPTH  = 512,
  parameter int LVL_W       = 10,
  parameter int ADDR_W      = 32
) (
  input  logic              hdmi_clk,
  input  logic              sync_rst,
  input  logic              hdmi_Pre_vsync,
  input  logic [ADDR_W-1:0] rd_base_addr,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_len,
  input  logic              rd_ack,
  input  logic              rd_data_vld,
  input  logic [LVL_W-1:0]  fifo_wr_cnt,
  output logic              fifo_flush,
  output logic              frame_done,
  output logic              rsp_err
);

  state_e            state, state_nxt;
  logic              vs_d, vs_rise;
  logic [ADDR_W-1:0] base_q;
  logic [FW_W-1:0]   req_words, ret_words, remaining;
  logic [7:0]        len;
  logic              ack_fire;
  logic              abort_q, abort_nxt;
  logic              issue, flush_nxt, done_nxt;
  logic              credit_ok;
  logic [LVL_W:0]    outst;

  assign vs_rise   = hdmi_Pre_vsync & ~vs_d;
  assign ack_fire  = rd_req & rd_ack;
  assign remaining = FW_W'(FRAME_WORDS) - req_words;
  assign len       = (remaining < FW_W'(BURST_LEN)) ? remaining[7:0] : 8'(BURST_LEN);

  hdmi_rd_credit #(
    .LVL_W      (LVL_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_credit (
    .clk         (hdmi_clk),
    .sync_rst    (sync_rst),
    .ack_fire    (ack_fire),
    .ack_len     (rd_len),
    .data_vld    (rd_data_vld),
    .fifo_wr_cnt (fifo_wr_cnt),
    .req_len     (len),
    .outst       (outst),
    .credit_ok   (credit_ok),
    .rsp_err     (rsp_err)
  );

  always_ff @(posedge hdmi_clk) begin
    if (sync_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    abort_nxt = abort_q;
    issue     = 1'b0;
    flush_nxt = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: if (vs_rise) state_nxt = DRAIN;
      DRAIN: begin
        // A fresh vsync only moves the base; the flush waits one more cycle.
        if (!vs_rise && (outst == '0)) begin
          flush_nxt = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN, WAIT: begin
        if (vs_rise || abort_q) begin
          // A command already presented must finish its handshake first.
          if (!rd_req || rd_ack) begin
            state_nxt = DRAIN;
            abort_nxt = 1'b0;
          end else begin
            abort_nxt = 1'b1;
          end
        end else begin
          if (rd_data_vld && (ret_words == FW_W'(FRAME_WORDS - 1))) done_nxt = 1'b1;
          if ((state == RUN) && !rd_req) begin
            if (req_words == FW_W'(FRAME_WORDS)) state_nxt = WAIT;
            else if (credit_ok)                  issue     = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge hdmi_clk) begin
    if (sync_rst) begin
      vs_d       <= 1'b0;
      base_q     <= '0;
      abort_q    <= 1'b0;
      req_words  <= '0;
      ret_words  <= '0;
      rd_req     <= 1'b0;
      rd_addr    <= '0;
      rd_len     <= '0;
      fifo_flush <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      vs_d       <= hdmi_Pre_vsync;
      abort_q    <= abort_nxt;
      fifo_flush <= flush_nxt;
      frame_done <= done_nxt;
      if (vs_rise) base_q <= rd_base_addr;

      if (flush_nxt) begin
        req_words <= '0;
        ret_words <= '0;
      end else begin
        if (ack_fire) req_words <= req_words + FW_W'(rd_len);
        if (rd_data_vld && ((state == RUN) || (state == WAIT)))
          ret_words <= ret_words + FW_W'(1);
      end

      if (issue) begin
        rd_req  <= 1'b1;
        rd_addr <= base_q + ADDR_W'(req_words) * ADDR_W'(WORD_BYTES);
        rd_len  <= len;
      end else if (ack_fire) begin
        rd_req <= 1'b0;
      end
    end
  end

endmodule

// File: doc/hdmi_rd_sched.md
Name: hdmi_rd_sched

Overview:
- Schedules frame-buffer burst reads that keep the 256-bit pixel FIFO ahead of the HDMI scan-out buffer.
- Sits between the DDR read master (req/ack command port plus a returned-data strobe) and the pixel FIFO's write side.
- Each frame: restarts at the vsync edge, flushes the FIFO, then issues bursts only when the FIFO has credit for them.
- Entirely in the hdmi_clk domain.

Parameters:
- FRAME_WORDS, 259200: 256-bit words per frame (1920x1080x32bpp / 256).
- BURST_LEN, 64: words per full burst, range 1..255.
- FIFO_DEPTH, 512: pixel FIFO capacity in words.
- LVL_W, 10: width of the FIFO level input; must hold FIFO_DEPTH.
- ADDR_W, 32: byte-address width.

Ports:
- hdmi_clk  in  1  sole clock.
- sync_rst  in  1  synchronous, active-high reset.
- hdmi_Pre_vsync  in  1  active-high vsync; a rising edge starts a frame.
- rd_base_addr  in  ADDR_W  frame base address, sampled on the vsync rising edge.
- rd_req  out  1  burst command valid.
- rd_addr  out  ADDR_W  burst byte address.
- rd_len  out  8  burst length in words (1..BURST_LEN).
- rd_ack  in  1  command accepted this cycle.
- rd_data_vld  in  1  one returned word written to the FIFO this cycle.
- fifo_wr_cnt  in  LVL_W  current FIFO occupancy.
- fifo_flush  out  1  one-cycle FIFO clear pulse.
- frame_done  out  1  one-cycle pulse when the last word of the frame has returned.
- rsp_err  out  1  sticky: a word was returned with nothing outstanding.

Behaviour:
- Reset values:
  - rd_req=0, rd_addr=0, rd_len=0, fifo_flush=0, frame_done=0, rsp_err=0.
  - State=IDLE; all counters 0; vsync edge register=0.
- Vsync edge: vs_d is hdmi_Pre_vsync registered once. vs_rise = hdmi_Pre_vsync & ~vs_d. vs_rise latches rd_base_addr into base_q.
- Counters:
  - outst: words requested but not yet returned, width LVL_W+1.
  - req_words: words requested this frame, width 20.
  - ret_words: words returned this frame, width 20.
- outst update each cycle:
  - +rd_len on an ack cycle (rd_req & rd_ack).
  - -1 on rd_data_vld.
  - Both in the same cycle: net change.
  - rd_data_vld with outst==0: outst stays 0, rsp_err sets and clears only on reset.
- State machine:
  - IDLE: vs_rise -> DRAIN.
  - DRAIN: wait for outst==0; in-flight data from an aborted frame is still counted. When outst==0: assert fifo_flush for that single cycle, clear req_words and ret_words, go to RUN.
  - RUN:
    - When not requesting, compute len = min(BURST_LEN, FRAME_WORDS - req_words).
    - Issue when fifo_wr_cnt + outst + len <= FIFO_DEPTH: rd_req=1, rd_addr = base_q + req_words*32, rd_len=len, all registered.
    - rd_req, rd_addr and rd_len hold stable until rd_ack.
    - On the ack cycle, req_words += len; rd_req drops next cycle. The next request is issued no earlier than the cycle after that.
    - When req_words == FRAME_WORDS and no request is pending -> WAIT.
  - WAIT:
    - frame_done pulses on the cycle after ret_words reaches FRAME_WORDS.
    - vs_rise -> DRAIN.
- Vsync mid-frame (RUN or WAIT, frame incomplete):
  - A pending rd_req stays up until acked; then go to DRAIN.
  - No new request is issued after vs_rise.
  - The early frame_done pulse is suppressed.
- vs_rise while already in DRAIN: re-latch base_q and stay in DRAIN.
- Short final burst: len may be < BURST_LEN when FRAME_WORDS is not a multiple of BURST_LEN.
- Credit arithmetic: evaluated at LVL_W+2 bits, so no overflow.
- sync_rst mid-burst: all state returns to reset values. A rd_ack arriving in the same cycle as sync_rst is ignored.

Decomposition:
- Shared package hdmi_pkg:
  - Localparams WORD_BYTES=32 and a frame-word counter width of 20.
  - State enum {IDLE, DRAIN, RUN, WAIT}.
- One natural sub-module: hdmi_rd_credit. It holds the outst counter, the credit compare and rsp_err.
- FSM, address generation and vsync edge detection stay in the top.

Test Plan:
- Reset, then vsync pulse with base=0x1000_0000 and fifo_wr_cnt=0:
  - fifo_flush pulses exactly 1 cycle.
  - First rd_req has rd_addr=0x1000_0000 and rd_len=64; the second has rd_addr=0x1000_0800.
- fifo_wr_cnt=448 with outst=0: a 64-word burst issues. At fifo_wr_cnt=449, no rd_req until the level drops.
- FRAME_WORDS=100, BURST_LEN=64:
  - Bursts have lengths 64 then 36; 36 is at address base+0x800.
  - frame_done pulses once, the cycle after the 100th rd_data_vld.
- Vsync mid-frame with 64 words outstanding:
  - Pending rd_req completes its ack and no further requests issue.
  - fifo_flush pulses only after the 64th returned word.
  - A new frame starts at the newly latched base.
- rd_ack and rd_data_vld in the same cycle: outst = old+len-1. rd_data_vld with outst=0 sets rsp_err, which stays set until sync_rst.
- sync_rst asserted while rd_req=1: next cycle, all outputs are 0 and state is IDLE.
